// File: rtl/simon_sequence_player_pkg.sv
// Shared Simon definitions: playback FSM encodings and default sizing,
// common to the sequence player and the game controller.
package simon_sequence_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ON     = 2'd1,
    ST_OFF    = 2'd2,
    ST_FINISH = 2'd3
  } play_state_t;

  localparam int DEFAULT_MAX_LEN   = 16;
  localparam int DEFAULT_ON_TICKS  = 4;
  localparam int DEFAULT_OFF_TICKS = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_tick_counter.sv
// Loadable down-counter that steps once per tick; expire flags the tick
// that completes the loaded interval.
module simon_tick_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // A reload always beats a decrement so the next interval starts cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == WIDTH'(1));

endmodule

// File: rtl/simon_sequence_player.sv
// Stores the Simon colour sequence and plays it back as timed pressed/num
// pulses paced by the game tick.
module simon_sequence_player
  import simon_sequence_player_pkg::*;
#(
  parameter int MAX_LEN   = DEFAULT_MAX_LEN,
  parameter int ON_TICKS  = DEFAULT_ON_TICKS,
  parameter int OFF_TICKS = DEFAULT_OFF_TICKS,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             append_valid,
  input  logic [1:0]       append_num,
  output logic             append_ack,
  input  logic             clear,
  input  logic             start,
  output logic [1:0]       num,
  output logic             pressed,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] length,
  output logic             full
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(max_int(ON_TICKS, OFF_TICKS) + 1);

  play_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [LEN_W-1:0] length_q;
  logic             ack_q;
  logic [1:0]       mem [MAX_LEN];

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_expire;
  logic             append_accept;

  assign busy          = (state_q == ST_ON) || (state_q == ST_OFF);
  assign full          = (length_q == LEN_W'(MAX_LEN));
  assign append_accept = append_valid && !busy && !full && !clear;
  assign length        = length_q;
  assign append_ack    = ack_q;
  assign pressed       = (state_q == ST_ON);
  assign done          = (state_q == ST_FINISH);
  assign num           = pressed ? mem[idx_q] : 2'b00;

  simon_tick_counter #(.WIDTH(CNT_W)) u_tick_counter (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (cnt_load),
    .load_value (cnt_value),
    .expire     (cnt_expire)
  );

  // Entries are never reset; a zero length makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (append_accept) begin
      mem[length_q[IDX_W-1:0]] <= append_num;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      length_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ack_q   <= append_accept;
      if (clear && !busy) begin
        length_q <= '0;
      end else if (append_accept) begin
        length_q <= length_q + 1'b1;
      end
    end
  end

  // The last index is captured at start so a same-cycle append cannot stretch playback.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_load  = 1'b0;
    cnt_value = CNT_W'(ON_TICKS);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length_q != '0) begin
            state_d  = ST_ON;
            idx_d    = '0;
            last_d   = IDX_W'(length_q - 1'b1);
            cnt_load = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_ON: begin
        if (cnt_expire) begin
          state_d   = ST_OFF;
          cnt_load  = 1'b1;
          cnt_value = CNT_W'(OFF_TICKS);
        end
      end
      ST_OFF: begin
        if (cnt_expire) begin
          if (idx_q == last_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d  = ST_ON;
            idx_d    = idx_q + 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/simon_sequence_player.md
SIMON_SEQUENCE_PLAYER -- requirements
Module: simon_sequence_player

Interface
REQ-001 Parameter MAX_LEN, default 16: sequence capacity in entries, power of two.
REQ-002 Parameter ON_TICKS, default 4: tick pulses each entry is presented with pressed high.
REQ-003 Parameter OFF_TICKS, default 2: tick pulses of silence after each entry.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  one-clk-wide timing strobe from the game clock reducer.
REQ-007 append_valid  input  1  request to append append_num to the sequence.
REQ-008 append_num  input  2  color/button code to append.
REQ-009 append_ack  output  1  one-cycle pulse: append accepted.
REQ-010 clear  input  1  empty the sequence (length := 0).
REQ-011 start  input  1  one-cycle request to play the stored sequence.
REQ-012 num  output  2  code currently presented; 0 when pressed low.
REQ-013 pressed  output  1  high while an entry is presented (feeds LED/tone path).
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse at end of playback.
REQ-016 length  output  $clog2(MAX_LEN+1)  entries stored (5 bits at default).
REQ-017 full  output  1  high when length == MAX_LEN.

Function
REQ-018 Storage: MAX_LEN x 2-bit register array, written only at index length.
REQ-019 Append accepted iff append_valid & !busy & !full & !clear; entry written, length+1, append_ack high next cycle.
REQ-020 Append while busy or full: ignored, no ack, array/length unchanged.
REQ-021 clear while !busy: length := 0 next cycle, array contents don't-care; clear while busy ignored.
REQ-022 clear and append_valid same cycle: clear wins, no ack.
REQ-023 FSM states IDLE, ON, OFF, FINISH.
REQ-024 IDLE: start & length>0 -> ON, idx := 0, counter := ON_TICKS; start & length==0 -> FINISH.
REQ-025 ON: pressed=1, num=mem[idx]; counter decrements on each tick; on the ON_TICKS-th tick -> OFF, counter := OFF_TICKS.
REQ-026 OFF: pressed=0, num=0; on the OFF_TICKS-th tick: if idx==length-1 -> FINISH, else idx+1, -> ON, counter := ON_TICKS.
REQ-027 FINISH: done=1 for exactly one clk, busy=0 in that cycle, -> IDLE.
REQ-028 busy high in ON and OFF only; pressed and done never high together.
REQ-029 start while busy or in FINISH ignored; start does not require tick.
REQ-030 Cycles without tick hold state and counter; tick in IDLE/FINISH ignored.
REQ-031 length sampled at start; appends blocked during playback so playback length is fixed.
REQ-032 Playback duration = length*(ON_TICKS+OFF_TICKS) ticks, plus one clk for FINISH.
REQ-033 Counter width $clog2(max(ON_TICKS,OFF_TICKS)+1); idx width $clog2(MAX_LEN); no wrap beyond MAX_LEN-1.

Reset
REQ-034 reset asserted at any time, including mid-playback: state IDLE, length=0, idx=0, counter=0, num=0, pressed=0, busy=0, done=0, append_ack=0, full=0; no done pulse issued for aborted playback.
REQ-035 Array contents need not be reset (length=0 makes them unreachable).

Structure
REQ-036 FSM state encodings and default MAX_LEN/ON_TICKS/OFF_TICKS in shared simon_defs include, also used by the game controller.
REQ-037 One sub-module natural: simon_tick_counter (loadable down-counter, decrements on tick, terminal flag); rest in one module.

Verification
REQ-038 Append 2,0,3 in IDLE -> three append_ack pulses, length=3, full=0.
REQ-039 start with sequence 2,0,3, tick every 4 clk, defaults -> pressed/num: 2 for 4 ticks, 0-off 2 ticks, 0 for 4, off 2, 3 for 4, off 2; done one clk after 18th tick; busy low thereafter.
REQ-040 Append 16 entries then a 17th -> 17th no ack, full=1, length=16; clear -> length=0, full=0.
REQ-041 start with length=0 -> done pulse next cycle, pressed never high, busy never high.
REQ-042 append_valid and start during playback -> no ack, length unchanged, playback unaffected.
REQ-043 reset asserted in ON of 2nd entry -> same cycle pressed=0, busy=0, length=0; no done; subsequent start does nothing but emit done.
